// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch unit. Owns the PC, buffers {pc, instr} in a
//            small FIFO towards decode, handles redirects, halts on bad PCs.
//            Optional perf counters: define INSTR_FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam int          c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] c_imem_limit = 32'(IMEM_WORDS * 4);
  localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(FIFO_DEPTH);

  localparam logic [0:0] c_st_fetch = 1'b0;
  localparam logic [0:0] c_st_halt  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        fifo_pc_q  [FIFO_DEPTH];
  logic [31:0]        fifo_ins_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_ptr_w:0]   count_q;
  logic               fault_q;
  logic [31:0]        fault_pc_q;

  logic w_pop, w_full, w_bad, w_push, w_flush, w_fault;

  assign w_pop  = out_valid & out_ready;
  assign w_full = (count_q == c_full_cnt);
  assign w_bad  = (pc_q[1:0] != 2'b00) || (pc_q >= c_imem_limit);

  // Redirect outranks the range check: a bad target is caught on the next cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_push  = 1'b0;
    w_flush = 1'b0;
    w_fault = 1'b0;
    if (state_q == c_st_fetch) begin
      if (redirect_valid) begin
        w_flush = 1'b1;
        pc_d    = redirect_pc;
      end else if (w_bad) begin
        w_fault = 1'b1;
        state_d = c_st_halt;
      end else if (!w_full || w_pop) begin
        w_push = 1'b1;
        pc_d   = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_fetch;
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (w_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
      if (w_fault) begin
        fault_q    <= 1'b1;
        fault_pc_q <= pc_q;
      end
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      fifo_pc_q[wr_ptr_q]  <= pc_q;
      fifo_ins_q[wr_ptr_q] <= instr;
    end
  end

  assign instr_addr  = pc_q;
  assign out_valid   = (count_q != '0);
  assign out_instr   = out_valid ? fifo_ins_q[rd_ptr_q] : 32'h0;
  assign out_pc      = out_valid ? fifo_pc_q[rd_ptr_q]  : 32'h0;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        w_stall;

  assign w_stall = (state_q == c_st_fetch) && !redirect_valid && !w_bad && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (w_push)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (w_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule
`default_nettype wire
